// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box table, round constants,
// key-schedule state encoding and round-key word count.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT, STEP} ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [5:0] i);
    case (i)
      6'd1:    rcon = 8'h01;
      6'd2:    rcon = 8'h02;
      6'd3:    rcon = 8'h04;
      6'd4:    rcon = 8'h08;
      6'd5:    rcon = 8'h10;
      6'd6:    rcon = 8'h20;
      6'd7:    rcon = 8'h40;
      6'd8:    rcon = 8'h80;
      6'd9:    rcon = 8'h1b;
      6'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic int unsigned nw_of(input int unsigned nr);
    return 4 * (nr + 1);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// 32-bit AES SubWord: four parallel S-box lookups, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign dout[8*b +: 8] = SBOX[din[8*b +: 8]];
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES round-key generator in reverse order: expands forward through an
// Nk-word window, then walks the schedule backwards one word per cycle.
module aes_inv_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 8,
  parameter int unsigned Nr = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] Key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] RoundKey,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         done
);

  localparam int unsigned NW = nw_of(Nr);

  if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_cfg
    $error("aes_inv_key_schedule: illegal Nk/Nr pair");
  end

  ks_state_e   state, state_nxt;
  logic [31:0] win [Nk];
  logic [5:0]  j;
  logic [1:0]  step_cnt;
  logic [3:0]  r;

  logic [5:0]  k, kmod, kdiv, off;
  logic [31:0] prev, sub_in, sub_out, temp;

  // j is the next word to compute, so the window holds w[j-Nk .. j-1].
  // STEP recovers w[k-Nk] with k = j-1 from the same temp rule as EXPAND.
  always_comb begin
    k      = (state == STEP) ? j - 6'd1 : j;
    prev   = (state == STEP) ? win[Nk-2] : win[Nk-1];
    kmod   = k % 6'(Nk);
    kdiv   = k / 6'(Nk);
    sub_in = (kmod == '0) ? {prev[23:0], prev[31:24]} : prev;
    temp   = prev;
    if (kmod == '0)
      temp = sub_out ^ {rcon(kdiv), 24'h000000};
    else if (Nk == 8 && kmod == 6'd4)
      temp = sub_out;
  end

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXPAND;
      EXPAND:  if (j == 6'(NW - 1)) state_nxt = EMIT;
      EMIT:    if (rk_ready) state_nxt = (r == '0) ? IDLE : STEP;
      STEP:    if (step_cnt == 2'd3) state_nxt = EMIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Nk; i++) win[i] <= '0;
      j        <= '0;
      step_cnt <= '0;
      r        <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < Nk; i++) win[i] <= Key[255 - 32*i -: 32];
            j <= 6'(Nk);
          end
        end
        EXPAND: begin
          for (int unsigned i = 0; i < Nk - 1; i++) win[i] <= win[i+1];
          win[Nk-1] <= win[0] ^ temp;
          j         <= j + 6'd1;
          if (j == 6'(NW - 1)) r <= 4'(Nr);
        end
        EMIT: begin
          step_cnt <= '0;
          if (rk_ready && r == '0) done <= 1'b1;
        end
        STEP: begin
          step_cnt <= step_cnt + 2'd1;
          // Once w0 sits at the window bottom the remaining keys are all
          // resident; the step cycles still elapse to keep latency uniform.
          if (j > 6'(Nk)) begin
            win[0] <= win[Nk-1] ^ temp;
            for (int unsigned i = 1; i < Nk; i++) win[i] <= win[i-1];
            j <= j - 6'd1;
          end
          if (step_cnt == 2'd3) r <= r - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign rk_valid = (state == EMIT);
  assign rk_index = r;
  assign rk_last  = rk_valid && (r == '0);

  // Window index of w[4r]; equals Nk-4 until the window bottoms out at w0.
  always_comb begin
    RoundKey = '0;
    off      = {r, 2'b00} + 6'(Nk) - j;
    if (rk_valid) begin
      for (int unsigned m = 0; m < 4; m++)
        for (int unsigned i = 0; i < Nk; i++)
          if (off + 6'(m) == 6'(i)) RoundKey[127 - 32*m -: 32] = win[i];
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule across AES-128/192/256,
// compared against a reference key expansion built from GF(2^8) arithmetic.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_v [3];
  logic [255:0] key_v   [3];
  logic         ready_v [3];
  logic         busy_v  [3];
  logic         valid_v [3];
  logic         last_v  [3];
  logic         done_v  [3];
  logic [127:0] rk_v    [3];
  logic [3:0]   idx_v   [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb     [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];
  int           last_first;
  int           last_done;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_key_schedule #(.Nk(4 + 2*g), .Nr(10 + 2*g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_v[g]),
      .Key      (key_v[g]),
      .busy     (busy_v[g]),
      .rk_valid (valid_v[g]),
      .rk_ready (ready_v[g]),
      .RoundKey (rk_v[g]),
      .rk_index (idx_v[g]),
      .rk_last  (last_v[g]),
      .done     (done_v[g])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] t = b;
    for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
    return t;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic ref_expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_idle(input int c, input string tag);
    check_eq({tag, "_busy"},  busy_v[c],  0);
    check_eq({tag, "_valid"}, valid_v[c], 0);
    check_eq({tag, "_done"},  done_v[c],  0);
    check_eq({tag, "_last"},  last_v[c],  0);
    check_eq({tag, "_rk"},    rk_v[c],    0);
    check_eq({tag, "_idx"},   idx_v[c],   0);
  endtask

  // Runs one schedule on instance c; abort_r >= 0 pulls reset during the
  // STEP phase that follows the handshake of round abort_r.
  task automatic run_sched(input int c, input logic [255:0] key, input int stall_pct, input int abort_r);
    int nk = 4 + 2*c;
    int nr = 10 + 2*c;
    int cyc, er;
    logic stalled = 1'b0;
    logic [127:0] held_rk = '0;
    logic [3:0]   held_idx = '0;
    ref_expand(key, nk, nr);
    for (int i = 0; i < 15; i++) got_rk[i] = '0;
    last_first = -1;
    last_done  = -1;
    key_v[c] = key;
    start_v[c] = 1'b1;
    ready_v[c] = 1'b1;
    @(posedge clk); #1;
    start_v[c] = 1'b0;
    key_v[c] = ~key;
    cyc = 1;
    er  = nr;
    check_eq("busy_after_start", busy_v[c], 1);
    while (cyc < 2000 && last_done < 0) begin
      if (abort_r >= 0 && er == abort_r - 1 && !valid_v[c]) begin
        #2 reset = 1'b0;
        #1 check_eq("abort_busy",  busy_v[c],  0);
        check_eq("abort_valid", valid_v[c], 0);
        check_eq("abort_done",  done_v[c],  0);
        check_eq("abort_rk",    rk_v[c],    0);
        @(posedge clk); #1;
        check_eq("abort_done_hold", done_v[c], 0);
        reset = 1'b1;
        ready_v[c] = 1'b0;
        @(posedge clk); #1;
        return;
      end
      start_v[c] = (cyc == 3 || cyc == 60);
      if (done_v[c]) begin
        last_done = cyc;
        check_eq("keys_before_done", nr - er, nr + 1);
      end else begin
        if (stalled) begin
          check_eq("stall_valid", valid_v[c], 1);
          check_eq("stall_rk",    rk_v[c],    held_rk);
          check_eq("stall_idx",   idx_v[c],   held_idx);
        end
        if (valid_v[c] && last_first < 0) last_first = cyc;
        ready_v[c] = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
        if (valid_v[c] && ready_v[c]) begin
          if (er < 0) begin
            check_eq("extra_key", valid_v[c], 0);
          end else begin
            check_eq($sformatf("rk_index_r%0d", er), idx_v[c], er);
            check_eq($sformatf("rk_r%0d", er), rk_v[c], exp_rk[er]);
            check_eq($sformatf("rk_last_r%0d", er), last_v[c], (er == 0));
            got_rk[idx_v[c]] = rk_v[c];
          end
          er--;
        end
        stalled  = valid_v[c] && !ready_v[c];
        held_rk  = rk_v[c];
        held_idx = idx_v[c];
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_v[c] = 1'b0;
    ready_v[c] = 1'b0;
    check_eq("done_seen", (last_done >= 0), 1);
    check_eq("done_single_pulse", done_v[c], 0);
    check_eq("idle_after_done", busy_v[c], 0);
  endtask

  initial begin
    logic [255:0] rkey;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      start_v[c] = 1'b0;
      key_v[c]   = '0;
      ready_v[c] = 1'b0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) check_idle(c, "reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // AES-128
    run_sched(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, -1);
    check_eq("aes128_first_cycle", last_first, 41);
    check_eq("aes128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_eq("aes128_rk1",  got_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("aes128_rk0",  got_rk[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

    // AES-192
    run_sched(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 0, -1);
    check_eq("aes192_first_cycle", last_first, 47);
    check_eq("aes192_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    check_eq("aes192_rk0",  got_rk[0],  128'h8e73b0f7da0e6452c810f32b809079e5);

    // AES-256
    run_sched(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0, -1);
    check_eq("aes256_first_cycle", last_first, 53);
    check_eq("aes256_done_cycle",  last_done, 124);
    check_eq("aes256_rk14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check_eq("aes256_rk0",  got_rk[0],  128'h000102030405060708090a0b0c0d0e0f);

    // Backpressure
    run_sched(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 40, -1);
    check_eq("bp_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset during STEP, then a full rerun of the same key
    rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_sched(2, rkey, 0, 10);
    check_idle(2, "post_abort");
    run_sched(2, rkey, 0, -1);

    // Random keys on every key size, with random stalls
    for (int c = 0; c < 3; c++) begin
      for (int n = 0; n < 2; n++) begin
        rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_sched(c, rkey, 30, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Generates AES round keys in reverse order (Nr down to 0) for an iterative inverse-cipher datapath.
- Runs the forward key expansion one word per cycle until it reaches the final Nk words. Then it walks the schedule backwards one word per cycle, emitting each 128-bit round key through a valid/ready handshake.
- Sits between the key register and the decryption round engine. No full round-key RAM is needed; storage is one Nk-word window.

Parameters:
- Nk, 8, key length in 32-bit words. Legal values are 4, 6, 8.
- Nr, 14, number of rounds. Legal pairs are (4,10), (6,12), (8,14); any other pair is a compile-time error.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a schedule. Sampled only in IDLE.
- Key  input  256  cipher key, bit 0 = MSB. Uses the leftmost Nk*32 bits; the rest are ignored.
- busy  output  1  high from the cycle after start is accepted until done.
- rk_valid  output  1  round key available.
- rk_ready  input  1  consumer accepts the round key.
- RoundKey  output  128  current round key, words w[4r..4r+3], bit 0 = MSB.
- rk_index  output  4  round number r of RoundKey.
- rk_last  output  1  high with rk_valid when rk_index = 0.
- done  output  1  one-cycle pulse after the round-0 key handshake.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. busy, rk_valid, rk_last and done are 0; RoundKey, rk_index, window and counter are 0.
- Constants: Nw = 4*(Nr+1), i.e. 44, 52 or 60 words.
- Window: Nk x 32-bit shift register. Word counter j, 6 bits.
- Round keys come from the top 4 words of the window.
- State IDLE:
  - On start, load the window with Key words w0..w(Nk-1), set j = Nk, go to EXPAND.
  - start in any other state is ignored.
- State EXPAND, one word per cycle:
  - temp = w[j-1].
  - If j mod Nk = 0: temp = SubWord(RotWord(temp)) xor Rcon[j/Nk].
  - Else if Nk = 8 and j mod Nk = 4: temp = SubWord(temp).
  - w[j] = w[j-Nk] xor temp. Shift the window up, j++.
  - After the cycle that computes w[Nw-1], go to EMIT.
  - EXPAND lasts Nw-Nk cycles: 40, 46 or 52.
- State EMIT:
  - rk_valid = 1, rk_index = r, RoundKey = top 4 window words. r starts at Nr.
  - RoundKey and rk_index are held stable while rk_valid=1 and rk_ready=0.
  - On handshake (rk_valid & rk_ready):
    - if r = 0, go to IDLE and pulse done next cycle;
    - otherwise go to STEP with k = Nw-1 - 4*(Nr-r).
- State STEP, 4 cycles, one word per cycle, for k descending:
  - Recover w[k-Nk] = w[k] xor temp(k), where temp(k) uses the same rule as EXPAND with j = k, applied to w[k-1].
  - Shift the window down. Then r--, go to EMIT.
- Shared S-box: exactly one SubWord instance (4 S-boxes), used by EXPAND and STEP. There is never more than one lookup per cycle.
- Latency with rk_ready tied high:
  - start accepted at cycle 0; first rk_valid at cycle Nw-Nk+1.
  - Each later key appears 5 cycles after the previous handshake.
  - done pulses 1 cycle after the rk_last handshake.
  - Nk=8 total: 53 + 14*5 + 1 = 124 cycles.
- busy is high in EXPAND, EMIT and STEP.
- rk_ready without rk_valid is ignored.
- Key changing after start is ignored; the key is sampled only at start.
- Reset asserted mid-schedule aborts immediately. No done pulse; outputs return to reset values.

Decomposition:
- Shared package aes_pkg holds:
  - the S-box constant table and Rcon[1..10];
  - state enum IDLE/EXPAND/EMIT/STEP;
  - a function computing Nw from Nr.
- One sub-module: aes_sub_word (32-bit SubWord, 4 S-box lookups, combinational), reusable by the cipher cores.

Test Plan:
- AES-128, Nk=4/Nr=10, Key=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - first rk_valid at cycle 41 with rk_index=10, RoundKey=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - rk_index=1 gives a0fafe1788542cb123a339392a6c7605;
  - rk_index=0 gives the key, with rk_last=1;
  - done pulses once.
- AES-192, Nk=6/Nr=12, Key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - first key at cycle 47 is e98ba06f448c773c8ecc720401002202, rk_index=12;
  - last key equals the first 128 key bits.
- AES-256, Nk=8/Nr=14, Key=000102…1e1f:
  - first key is 24fc79ccbf0979e9371ac23c6d68de36;
  - last key is 000102030405060708090a0b0c0d0e0f;
  - done at cycle 124.
- Backpressure: AES-256 Key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d98 10a30914dff4, rk_ready randomly low:
  - key 14 is fe4890d1e6188d0b046df344706c631e;
  - RoundKey and rk_index are stable while stalled;
  - sequence is 14..0 with no drops or duplicates.
- Protocol edges:
  - start pulsed while busy: no effect;
  - reset low during STEP: busy, rk_valid and done are 0 immediately;
  - a new start after reset reproduces the full correct sequence.
